// File: rtl/alu01.sv
// Registered ALU: one-cycle latency, result and carry/borrow/shift-out in a
// single WIDTH+1 bit output register, cleared asynchronously by rst_n.
module alu01 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH:0]   alu_out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOT  = 4'b0101,
        OP_NAND = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_XNOR = 4'b1000,
        OP_SHL  = 4'b1001,
        OP_SHR  = 4'b1010
    } op_t;

    logic [WIDTH:0] result;

    // Unused codes and X/Z on op never match an item, so they fall to zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            OP_AND:  result = {1'b0, a & b};
            OP_OR:   result = {1'b0, a | b};
            OP_XOR:  result = {1'b0, a ^ b};
            OP_NOT:  result = {1'b0, ~a};
            OP_NAND: result = {1'b0, ~(a & b)};
            OP_NOR:  result = {1'b0, ~(a | b)};
            OP_XNOR: result = {1'b0, ~(a ^ b)};
            OP_SHL:  result = {a, 1'b0};
            OP_SHR:  result = {a[0], 1'b0, a[WIDTH-1:1]};
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out <= '0;
        end else begin
            alu_out <= result;
        end
    end

endmodule

// File: tb/tb_alu01.sv
// Self-checking bench for alu01: directed vectors, boundaries, reset
// behaviour and randomized ops compared against an arithmetic reference.
module tb_alu01;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [8:0] alu_out;

    int n_tests;
    int n_fail;

    alu01 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .op      (op),
        .alu_out (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from plain integer arithmetic on the operand values.
    function automatic logic [8:0] ref_alu(int o, int x, int y);
        int r;
        case (o)
            0:  r = x + y;
            1:  r = (x - y + 512) % 512;
            2:  r = x & y;
            3:  r = x | y;
            4:  r = x ^ y;
            5:  r = 255 - x;
            6:  r = 255 - (x & y);
            7:  r = 255 - (x | y);
            8:  r = 255 - (x ^ y);
            9:  r = x * 2;
            10: r = (x % 2) * 256 + x / 2;
            default: r = 0;
        endcase
        return r[8:0];
    endfunction

    task automatic drive(input int o, input int x, input int y);
        @(negedge clk);
        op = o[3:0];
        a  = x[7:0];
        b  = y[7:0];
    endtask

    task automatic test_reset;
        logic [8:0] exp_v;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alu_out !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_assert: got %h expected %h", alu_out, 9'h000);
        end
        for (int i = 0; i < 6; i++) begin
            drive($urandom_range(0, 10), $urandom_range(0, 255), $urandom_range(0, 255));
            @(posedge clk);
            #1;
            n_tests++;
            if (alu_out !== 9'h000) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, alu_out, 9'h000);
            end
        end
        drive(0, 8'h12, 8'h34);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (alu_out !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_release_pre_edge: got %h expected %h", alu_out, 9'h000);
        end
        exp_v = 9'h046;
        @(posedge clk);
        #1;
        n_tests++;
        if (alu_out !== exp_v) begin
            n_fail++;
            $display("FAIL reset_release_first_edge: got %h expected %h", alu_out, exp_v);
        end
    endtask

    task automatic test_directed;
        logic [8:0] exp_tbl[11];
        exp_tbl = '{9'h115, 9'h1C1, 9'h02A, 9'h0EB, 9'h0C1, 9'h094,
                    9'h0D5, 9'h014, 9'h03E, 9'h0D6, 9'h135};
        for (int o = 0; o < 11; o++) begin
            drive(o, 8'h6B, 8'hAA);
            @(posedge clk);
            #1;
            n_tests++;
            if (alu_out !== exp_tbl[o]) begin
                n_fail++;
                $display("FAIL directed_op%0d: got %h expected %h", o, alu_out, exp_tbl[o]);
            end
        end
    endtask

    task automatic test_boundaries;
        int cases[6][3];
        logic [8:0] exp_v[6];
        cases = '{'{0, 255, 255}, '{1, 0, 1}, '{1, 8'h5A, 8'h5A},
                  '{9, 255, 0}, '{10, 1, 0}, '{1, 255, 0}};
        exp_v = '{9'h1FE, 9'h1FF, 9'h000, 9'h1FE, 9'h100, 9'h0FF};
        for (int i = 0; i < 6; i++) begin
            drive(cases[i][0], cases[i][1], cases[i][2]);
            @(posedge clk);
            #1;
            n_tests++;
            if (alu_out !== exp_v[i]) begin
                n_fail++;
                $display("FAIL boundary[%0d]: got %h expected %h", i, alu_out, exp_v[i]);
            end
        end
        for (int o = 11; o < 16; o++) begin
            drive(0, 8'hFF, 8'hFF);
            @(posedge clk);
            drive(o, $urandom_range(0, 255), $urandom_range(0, 255));
            @(posedge clk);
            #1;
            n_tests++;
            if (alu_out !== 9'h000) begin
                n_fail++;
                $display("FAIL unused_op%0d: got %h expected %h", o, alu_out, 9'h000);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic [8:0] exp_v;
        drive(0, 8'hF0, 8'h33);
        @(posedge clk);
        #1;
        n_tests++;
        if (alu_out !== 9'h123) begin
            n_fail++;
            $display("FAIL mid_reset_setup: got %h expected %h", alu_out, 9'h123);
        end
        @(negedge clk);
        op = 4'd3;
        a  = 8'h0F;
        b  = 8'h50;
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (alu_out !== 9'h000) begin
            n_fail++;
            $display("FAIL mid_reset_immediate: got %h expected %h", alu_out, 9'h000);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (alu_out !== 9'h000) begin
            n_fail++;
            $display("FAIL mid_reset_edge_held: got %h expected %h", alu_out, 9'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (alu_out !== 9'h000) begin
            n_fail++;
            $display("FAIL mid_reset_released_no_edge: got %h expected %h", alu_out, 9'h000);
        end
        exp_v = ref_alu(3, 8'h0F, 8'h50);
        @(posedge clk);
        #1;
        n_tests++;
        if (alu_out !== exp_v) begin
            n_fail++;
            $display("FAIL mid_reset_first_edge: got %h expected %h", alu_out, exp_v);
        end
    endtask

    task automatic test_hold;
        logic [8:0] held;
        logic [8:0] exp_v;
        drive(4, 8'h3C, 8'h0F);
        @(posedge clk);
        #1;
        held = ref_alu(4, 8'h3C, 8'h0F);
        for (int i = 0; i < 3; i++) begin
            #1;
            op = 4'($urandom_range(0, 10));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            #1;
            n_tests++;
            if (alu_out !== held) begin
                n_fail++;
                $display("FAIL hold_between_edges[%0d]: got %h expected %h", i, alu_out, held);
            end
        end
        exp_v = ref_alu(int'(op), int'(a), int'(b));
        @(posedge clk);
        #1;
        n_tests++;
        if (alu_out !== exp_v) begin
            n_fail++;
            $display("FAIL hold_next_edge: got %h expected %h", alu_out, exp_v);
        end
    endtask

    task automatic test_random;
        logic [8:0] exp_q[$];
        logic [8:0] exp_v;
        int o, x, y;
        for (int i = 0; i < 300; i++) begin
            o = $urandom_range(0, 15);
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            drive(o, x, y);
            exp_q.push_back(ref_alu(o, x, y));
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            n_tests++;
            if (alu_out !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h",
                         i, o, x, y, alu_out, exp_v);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        a       = '0;
        b       = '0;
        op      = '0;
        test_reset();
        test_directed();
        test_boundaries();
        test_mid_reset();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
